// File: rtl/lfsr_gen.sv
// ---------------------------------------------------------------------------
// lfsr_gen -- seedable Fibonacci / Galois LFSR sequence generator.
//
// After a load with a nonzero seed, the register steps through its sequence.
// It advances once for each cycle in which the consumer accepts the value and
// a step is requested. The run stops when the sequence comes back to the
// seed. When period counting is built in, the count of advances at that
// point is the sequence period.
//
// Parameters
//   N      register width, 2..32
//   TAPS   Fibonacci tap mask; bit i set feeds lfsr_data[i] into the XOR
//   GPOLY  Galois mask; bit i set XORs the feedback bit into bit i
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-low reset
//   load_seed     in   load seed_data and start a run (wins over step)
//   seed_data     in   N  seed value; also the end-of-period compare value
//   mode          in   0 = Fibonacci, 1 = Galois; captured on an accepted load
//   step          in   advance request
//   out_ready     in   consumer accepts the current lfsr_data
//   lfsr_data     out  N  current register value
//   out_valid     out  lfsr_data is a valid sequence element (state RUN)
//   lfsr_done     out  sequence has returned to the seed
//   seed_err      out  last load attempt used the all-zero lockup seed
//   period_count  out  N  advances since the last accepted load
//
// Configuration macro
//   LFSR_GEN_PERIOD_EN  defined: period_count is a saturating advance counter.
//                       undefined: no counter is built and period_count is 0.
// ---------------------------------------------------------------------------
module lfsr_gen #(
  parameter int             N     = 8,
  parameter logic [N-1:0]   TAPS  = N'(8'hB8),
  parameter logic [N-1:0]   GPOLY = N'(8'h1D)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_seed,
  input  logic [N-1:0] seed_data,
  input  logic         mode,
  input  logic         step,
  input  logic         out_ready,
  output logic [N-1:0] lfsr_data,
  output logic         out_valid,
  output logic         lfsr_done,
  output logic         seed_err,
  output logic [N-1:0] period_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]   r_state;
  logic [N-1:0] r_lfsr;
  logic [N-1:0] r_seed;      // compare value, frozen at load time
  logic         r_mode;
  logic         r_done;
  logic         r_seed_err;

  logic         w_seed_ok;
  logic         w_advance;
  logic [N-1:0] w_fib_next;
  logic [N-1:0] w_gal_next;
  logic [N-1:0] w_next;
  logic         w_hit_seed;

  // The all-zero state is a lockup point for both structures, so it is
  // rejected as a seed.
  assign w_seed_ok  = (seed_data != '0);

  // A load in the same cycle suppresses the advance.
  assign w_advance  = (r_state == ST_RUN) && step && out_ready && !load_seed;

  assign w_fib_next = {r_lfsr[N-2:0], ^(r_lfsr & TAPS)};
  assign w_gal_next = (r_lfsr << 1) ^ ({N{r_lfsr[N-1]}} & GPOLY);

  // NOTE: every always_comb output gets a default assignment first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next = w_fib_next;
    if (r_mode) begin
      w_next = w_gal_next;
    end
  end

  // The period ends on the advance that produces the seed again.
  assign w_hit_seed = (w_next == r_seed);

  // NOTE: state registers use non-blocking assignments, so every register
  // samples the values from before the edge, regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_lfsr     <= '0;
      r_seed     <= '0;
      r_mode     <= 1'b0;
      r_done     <= 1'b0;
      r_seed_err <= 1'b0;
    end else if (load_seed) begin
      r_done <= 1'b0;
      if (w_seed_ok) begin
        r_state    <= ST_RUN;
        r_lfsr     <= seed_data;
        r_seed     <= seed_data;
        r_mode     <= mode;
        r_seed_err <= 1'b0;
      end else begin
        // Rejected load: the register value, seed and mode are kept.
        r_state    <= ST_IDLE;
        r_seed_err <= 1'b1;
      end
    end else if (w_advance) begin
      r_lfsr <= w_next;
      if (w_hit_seed) begin
        r_state <= ST_DONE;
        r_done  <= 1'b1;
      end
    end
  end

`ifdef LFSR_GEN_PERIOD_EN
  logic [N-1:0] r_count;

  // The counter saturates at all-ones, so a very long run never wraps to a
  // misleading small period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (load_seed && w_seed_ok) begin
      r_count <= '0;
    end else if (w_advance && (r_count != '1)) begin
      r_count <= r_count + N'(1);
    end
  end

  assign period_count = r_count;
`else
  assign period_count = '0;
`endif

  assign lfsr_data = r_lfsr;
  assign out_valid = (r_state == ST_RUN);
  assign lfsr_done = r_done;
  assign seed_err  = r_seed_err;

endmodule

// File: tb/tb_lfsr_gen.sv
// ---------------------------------------------------------------------------
// tb_lfsr_gen -- directed self-checking bench for lfsr_gen at N=4.
// TAPS=4'hC (x^4+x^3+1 Fibonacci) and GPOLY=4'h3 (x^4+x+1 Galois). Both
// are maximal-length, so the period is 15 in either mode. The expected
// sequences were worked out by hand.
// Inputs change 1 time unit after the rising edge, and outputs are checked
// at that same point.
// ---------------------------------------------------------------------------
module tb_lfsr_gen;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_seed;
  logic [N-1:0] seed_data;
  logic         mode;
  logic         step;
  logic         out_ready;
  logic [N-1:0] lfsr_data;
  logic         out_valid;
  logic         lfsr_done;
  logic         seed_err;
  logic [N-1:0] period_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [N-1:0] fib_seq [15];
  logic [N-1:0] gal_seq [15];

  lfsr_gen #(
    .N     (N),
    .TAPS  (4'hC),
    .GPOLY (4'h3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .load_seed    (load_seed),
    .seed_data    (seed_data),
    .mode         (mode),
    .step         (step),
    .out_ready    (out_ready),
    .lfsr_data    (lfsr_data),
    .out_valid    (out_valid),
    .lfsr_done    (lfsr_done),
    .seed_err     (seed_err),
    .period_count (period_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The expected count depends on whether the counter is built in.
  function automatic logic [N-1:0] exp_cnt(input int v);
`ifdef LFSR_GEN_PERIOD_EN
    return N'(v);
`else
    return (v == 0) ? '0 : '0;
`endif
  endfunction

  initial begin
    fib_seq = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    gal_seq = '{4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB, 4'h5,
                4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};

    reset     = 1'b0;
    load_seed = 1'b0;
    seed_data = '0;
    mode      = 1'b0;
    step      = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();

    // Reset state.
    check("rst_data",  lfsr_data,    0);
    check("rst_valid", out_valid,    0);
    check("rst_done",  lfsr_done,    0);
    check("rst_err",   seed_err,     0);
    check("rst_count", period_count, 0);

    reset = 1'b1;
    tick();
    check("idle_valid", out_valid, 0);

    // Fibonacci run from seed 1. The output is valid one cycle after the load.
    load_seed = 1'b1;
    seed_data = 4'h1;
    mode      = 1'b0;
    tick();
    load_seed = 1'b0;
    seed_data = 4'hF;  // seed is latched; this change must not affect the compare
    check("fib_load_data",  lfsr_data,    4'h1);
    check("fib_load_valid", out_valid,    1);
    check("fib_load_count", period_count, exp_cnt(0));
    step      = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check($sformatf("fib_seq[%0d]", i), lfsr_data, fib_seq[i]);
      check($sformatf("fib_cnt[%0d]", i), period_count, exp_cnt(i + 1));
      if (i < 14) check($sformatf("fib_nodone[%0d]", i), lfsr_done, 0);
    end
    check("fib_done",  lfsr_done, 1);
    check("fib_valid", out_valid, 0);

    // Stepping in DONE has no effect.
    tick();
    tick();
    check("done_hold_data",  lfsr_data,    4'h1);
    check("done_hold_count", period_count, exp_cnt(15));
    check("done_hold_done",  lfsr_done,    1);

    // Galois run from seed 1.
    step      = 1'b0;
    load_seed = 1'b1;
    seed_data = 4'h1;
    mode      = 1'b1;
    tick();
    load_seed = 1'b0;
    mode      = 1'b0;  // mode is latched at load
    check("gal_load_done",  lfsr_done, 0);
    check("gal_load_valid", out_valid, 1);
    step = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check($sformatf("gal_seq[%0d]", i), lfsr_data, gal_seq[i]);
    end
    check("gal_done",  lfsr_done,    1);
    check("gal_count", period_count, exp_cnt(15));

    // A zero seed is rejected, and the data holds.
    step      = 1'b0;
    load_seed = 1'b1;
    seed_data = 4'h0;
    tick();
    load_seed = 1'b0;
    check("zero_err",   seed_err,  1);
    check("zero_valid", out_valid, 0);
    check("zero_data",  lfsr_data, 4'h1);
    check("zero_done",  lfsr_done, 0);
    step = 1'b1;
    tick();
    check("idle_step_data", lfsr_data, 4'h1);

    // A good seed then clears the error.
    step      = 1'b0;
    load_seed = 1'b1;
    seed_data = 4'h5;
    mode      = 1'b0;
    tick();
    load_seed = 1'b0;
    check("seed5_err",   seed_err,  0);
    check("seed5_valid", out_valid, 1);
    check("seed5_data",  lfsr_data, 4'h5);

    // Backpressure freezes the register and the count.
    step = 1'b1;
    tick();
    check("bp_pre_data", lfsr_data, 4'hB);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp_data[%0d]", i),  lfsr_data,    4'hB);
      check($sformatf("bp_count[%0d]", i), period_count, exp_cnt(1));
    end
    out_ready = 1'b1;
    tick();
    check("bp_resume_data",  lfsr_data,    4'h7);
    check("bp_resume_count", period_count, exp_cnt(2));

    // Load wins over step on the same edge.
    load_seed = 1'b1;
    seed_data = 4'h7;
    tick();
    load_seed = 1'b0;
    step      = 1'b0;
    check("prio_data",  lfsr_data,    4'h7);
    check("prio_count", period_count, exp_cnt(0));

    // Reset in the middle of a run, after 5 advances.
    load_seed = 1'b1;
    seed_data = 4'h1;
    tick();
    load_seed = 1'b0;
    step      = 1'b1;
    repeat (5) tick();
    check("mid_data",  lfsr_data,    4'h6);
    check("mid_count", period_count, exp_cnt(5));
    reset = 1'b0;
    #1;
    check("arst_data",  lfsr_data,    0);
    check("arst_valid", out_valid,    0);
    check("arst_count", period_count, 0);
    check("arst_done",  lfsr_done,    0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    check("post_rst_valid", out_valid, 0);
    check("post_rst_data",  lfsr_data, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
